// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet/IPv4 transmit and receive paths.
package eth_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned IP_HEADER_LEN    = 20;
    localparam int unsigned IPV4_MAX_PAYLOAD = 1480;
    localparam byte_t       IPV4_VER_IHL     = 8'h45;
    localparam byte_t       PROTO_UDP        = 8'd17;

    // Number of 16-bit words summed by the header checksum (checksum field taken as zero).
    localparam int unsigned CSUM_WORDS = 9;

    typedef enum logic [2:0] {
        StIdle,
        StCsum,
        StHeader,
        StPayload,
        StDrain
    } tx_state_e;

endpackage

// File: rtl/ip_checksum.sv
// Combinational IPv4 header checksum: ones'-complement sum of nine words, folded and inverted.
module ip_checksum
    import eth_pkg::*;
(
    input  logic [CSUM_WORDS-1:0][15:0] words_i,
    output logic [15:0]                 csum_o
);

    logic [19:0] acc;
    logic [19:0] fold1;
    logic [19:0] fold2;

    // Nine 16-bit words fit in 20 bits; two end-around-carry folds always settle.
    always_comb begin
        acc = '0;
        for (int i = 0; i < CSUM_WORDS; i++) begin
            acc = acc + {4'h0, words_i[i]};
        end
        fold1  = {4'h0, acc[15:0]} + {16'h0, acc[19:16]};
        fold2  = {4'h0, fold1[15:0]} + {16'h0, fold1[19:16]};
        csum_o = ~fold2[15:0];
    end

endmodule

// File: rtl/ip_tx_builder.sv
// IPv4 transmit framer: prepends a 20-byte header to a length-checked payload stream.
module ip_tx_builder
    import eth_pkg::*;
#(
    parameter logic [31:0] SRC_IP             = 32'hC0A80101,
    parameter logic [31:0] DST_IP             = 32'hC0A80102,
    parameter logic [7:0]  TRANSPORT_PROTOCOL = PROTO_UDP,
    parameter logic [7:0]  TTL                = 8'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [15:0] tx_payload_len,
    input  byte_t       pl_data_in,
    input  logic        pl_valid,
    input  logic        pl_eof,
    output logic        pl_ready,
    input  logic        ip_ready,
    output byte_t       ip_data_out,
    output logic        ip_byte_valid,
    output logic        ip_eof,
    output logic        ip_err,
    output logic        busy
);

    tx_state_e   state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] ident_q, ident_d;
    logic [4:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] pl_cnt_q, pl_cnt_d;
    logic [15:0] csum_q, csum_d;
    byte_t       data_q, data_d;
    logic        valid_q, valid_d;
    logic        eof_q, eof_d;
    logic        err_q, err_d;

    logic [15:0] total_len;
    logic [15:0] csum_calc;
    byte_t       hdr_byte;
    logic        out_adv;
    logic        eof_pending;
    logic        eof_xfer;
    logic        len_ok;
    logic        last_byte;

    logic [CSUM_WORDS-1:0][15:0] csum_words;

    assign total_len   = len_q + 16'(IP_HEADER_LEN);
    // Output register may load whenever it is empty or its byte leaves this cycle.
    assign out_adv     = !valid_q || ip_ready;
    assign eof_pending = valid_q && eof_q;
    assign eof_xfer    = eof_pending && ip_ready;
    assign len_ok      = (tx_payload_len != 16'd0) &&
                         (tx_payload_len <= 16'(IPV4_MAX_PAYLOAD));
    assign last_byte   = (pl_cnt_q == len_q - 16'd1);

    assign csum_words = {{IPV4_VER_IHL, 8'h00}, total_len, ident_q, 16'h0000,
                         {TTL, TRANSPORT_PROTOCOL}, SRC_IP[31:16], SRC_IP[15:0],
                         DST_IP[31:16], DST_IP[15:0]};

    ip_checksum u_checksum (
        .words_i (csum_words),
        .csum_o  (csum_calc)
    );

    // Header byte selected by the header counter, MSB-first per field.
    always_comb begin
        hdr_byte = 8'h00;
        unique case (hdr_cnt_q)
            5'd0:    hdr_byte = IPV4_VER_IHL;
            5'd2:    hdr_byte = total_len[15:8];
            5'd3:    hdr_byte = total_len[7:0];
            5'd4:    hdr_byte = ident_q[15:8];
            5'd5:    hdr_byte = ident_q[7:0];
            5'd8:    hdr_byte = TTL;
            5'd9:    hdr_byte = TRANSPORT_PROTOCOL;
            5'd10:   hdr_byte = csum_q[15:8];
            5'd11:   hdr_byte = csum_q[7:0];
            5'd12:   hdr_byte = SRC_IP[31:24];
            5'd13:   hdr_byte = SRC_IP[23:16];
            5'd14:   hdr_byte = SRC_IP[15:8];
            5'd15:   hdr_byte = SRC_IP[7:0];
            5'd16:   hdr_byte = DST_IP[31:24];
            5'd17:   hdr_byte = DST_IP[23:16];
            5'd18:   hdr_byte = DST_IP[15:8];
            5'd19:   hdr_byte = DST_IP[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Next-state, output-register and handshake logic.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        hdr_cnt_d = hdr_cnt_q;
        pl_cnt_d  = pl_cnt_q;
        csum_d    = csum_q;
        data_d    = data_q;
        valid_d   = valid_q;
        eof_d     = eof_q;
        err_d     = 1'b0;
        pl_ready  = 1'b0;
        busy      = (state_q != StIdle);
        ident_d   = eof_xfer ? ident_q + 16'd1 : ident_q;

        // Current byte drains unless something reloads the register below.
        if (out_adv) begin
            valid_d = 1'b0;
            eof_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    if (len_ok) begin
                        len_d   = tx_payload_len;
                        state_d = StCsum;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StCsum: begin
                csum_d    = csum_calc;
                hdr_cnt_d = 5'd0;
                state_d   = StHeader;
            end
            StHeader: begin
                if (out_adv) begin
                    data_d  = hdr_byte;
                    valid_d = 1'b1;
                    if (hdr_cnt_q == 5'(IP_HEADER_LEN - 1)) begin
                        pl_cnt_d = 16'd0;
                        state_d  = StPayload;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 5'd1;
                    end
                end
            end
            StPayload: begin
                // Once the final byte is queued, hold here until it has left.
                if (eof_pending) begin
                    if (ip_ready) begin
                        state_d = StIdle;
                    end
                end else begin
                    pl_ready = out_adv;
                    if (pl_valid && out_adv) begin
                        data_d   = pl_data_in;
                        valid_d  = 1'b1;
                        pl_cnt_d = pl_cnt_q + 16'd1;
                        if (pl_eof) begin
                            eof_d = 1'b1;
                            err_d = !last_byte;
                        end else if (last_byte) begin
                            eof_d   = 1'b1;
                            err_d   = 1'b1;
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                pl_ready = 1'b1;
                if (pl_valid && pl_eof) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            len_q     <= 16'd0;
            ident_q   <= 16'd0;
            hdr_cnt_q <= 5'd0;
            pl_cnt_q  <= 16'd0;
            csum_q    <= 16'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            eof_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ident_q   <= ident_d;
            hdr_cnt_q <= hdr_cnt_d;
            pl_cnt_q  <= pl_cnt_d;
            csum_q    <= csum_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            eof_q     <= eof_d;
            err_q     <= err_d;
        end
    end

    assign ip_data_out   = data_q;
    assign ip_byte_valid = valid_q;
    assign ip_eof        = eof_q;
    assign ip_err        = err_q;

endmodule

// File: tb/tb_ip_tx_builder.sv
// Directed bench for ip_tx_builder with an expected-byte scoreboard.
module tb_ip_tx_builder;

    localparam logic [31:0] B_SRC   = 32'hC0A80101;
    localparam logic [31:0] B_DST   = 32'hC0A80102;
    localparam logic [7:0]  B_TTL   = 8'h40;
    localparam logic [7:0]  B_PROTO = 8'h11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_start;
    logic [15:0] tx_payload_len;
    logic [7:0]  pl_data_in;
    logic        pl_valid;
    logic        pl_eof;
    logic        pl_ready;
    logic        ip_ready;
    logic [7:0]  ip_data_out;
    logic        ip_byte_valid;
    logic        ip_eof;
    logic        ip_err;
    logic        busy;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int err_seen = 0;
    int exp_err  = 0;
    bit rnd_mode = 1'b0;

    logic [8:0] sb[$];

    always #5 clk = ~clk;

    ip_tx_builder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_start       (tx_start),
        .tx_payload_len (tx_payload_len),
        .pl_data_in     (pl_data_in),
        .pl_valid       (pl_valid),
        .pl_eof         (pl_eof),
        .pl_ready       (pl_ready),
        .ip_ready       (ip_ready),
        .ip_data_out    (ip_data_out),
        .ip_byte_valid  (ip_byte_valid),
        .ip_eof         (ip_eof),
        .ip_err         (ip_err),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] csum_model(input logic [15:0] tl, input logic [15:0] id);
        logic [31:0] s;
        s = 32'h4500 + 32'(tl) + 32'(id) + 32'({B_TTL, B_PROTO}) + 32'(B_SRC[31:16])
            + 32'(B_SRC[15:0]) + 32'(B_DST[31:16]) + 32'(B_DST[15:0]);
        while (s[31:16] != 16'd0) s = 32'(s[15:0]) + 32'(s[31:16]);
        return ~s[15:0];
    endfunction

    // Expected stream: 20 header bytes then payload bytes 1..nfwd, eof on the last.
    task automatic push_pkt(input int len, input int id, input int nfwd);
        logic [15:0] tl;
        logic [15:0] idv;
        logic [15:0] cs;
        logic [7:0]  hdr[20];
        tl  = 16'(len + 20);
        idv = 16'(id);
        cs  = csum_model(tl, idv);
        hdr = '{8'h45, 8'h00, tl[15:8], tl[7:0], idv[15:8], idv[7:0], 8'h00, 8'h00,
                B_TTL, B_PROTO, cs[15:8], cs[7:0], B_SRC[31:24], B_SRC[23:16],
                B_SRC[15:8], B_SRC[7:0], B_DST[31:24], B_DST[23:16], B_DST[15:8],
                B_DST[7:0]};
        for (int i = 0; i < 20; i++) sb.push_back({1'b0, hdr[i]});
        for (int k = 1; k <= nfwd; k++) sb.push_back({(k == nfwd), 8'(k)});
    endtask

    task automatic start_pkt(input int len);
        @(posedge clk);
        #1;
        tx_start       = 1'b1;
        tx_payload_len = 16'(len);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    // Offer bytes 1..n, pl_eof on byte eof_at (0 = never); each held until accepted.
    task automatic send_pl(input int n, input int eof_at);
        int t;
        for (int i = 1; i <= n; i++) begin
            pl_valid   = 1'b1;
            pl_data_in = 8'(i);
            pl_eof     = (i == eof_at);
            t = 0;
            forever begin
                @(negedge clk);
                if (pl_ready) break;
                t++;
                if (t > 500) break;
            end
            if (t > 500) chk("pl_accept_timeout", 32'(t), 32'd0);
            @(posedge clk);
            #1;
        end
        pl_valid = 1'b0;
        pl_eof   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_timeout"}, 32'(t < 3000), 32'd1);
        chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_err_pulses"}, 32'(err_seen), 32'(exp_err));
    endtask

    // Random 50% downstream backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rnd_mode) ip_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard checker: every transferred byte must match the next expected one.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && ip_err) err_seen++;
        if (rst_n && ip_byte_valid && ip_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_byte", 32'({ip_eof, ip_data_out}), 32'h200);
            end else begin
                e = sb.pop_front();
                chk("out_byte", 32'({ip_eof, ip_data_out}), 32'(e));
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        tx_start       = 1'b0;
        tx_payload_len = 16'd0;
        pl_data_in     = 8'h00;
        pl_valid       = 1'b0;
        pl_eof         = 1'b0;
        ip_ready       = 1'b1;

        #3;
        chk("rst_valid", 32'(ip_byte_valid), 32'd0);
        chk("rst_data", 32'(ip_data_out), 32'd0);
        chk("rst_eof_err", 32'({ip_eof, ip_err}), 32'd0);
        chk("rst_busy_ready", 32'({busy, pl_ready}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic packet, ident 0 (header checksum F77D).
        push_pkt(8, 0, 8);
        start_pkt(8);
        chk("busy_after_start", 32'(busy), 32'd1);
        send_pl(8, 8);
        wait_done("pkt0");

        // Identical packet, ident 1 (checksum F77C).
        push_pkt(8, 1, 8);
        start_pkt(8);
        send_pl(8, 8);
        wait_done("pkt1");

        // Same packet under random backpressure.
        rnd_mode = 1'b1;
        push_pkt(8, 2, 8);
        start_pkt(8);
        send_pl(8, 8);
        wait_done("pkt_bp");
        rnd_mode = 1'b0;
        ip_ready = 1'b1;

        // Short payload: eof on byte 5 of 8.
        push_pkt(8, 3, 5);
        exp_err++;
        start_pkt(8);
        send_pl(5, 5);
        wait_done("pkt_short");

        // Long payload: 10 bytes against len 4, bytes 5..10 dropped.
        push_pkt(4, 4, 4);
        exp_err++;
        start_pkt(4);
        send_pl(10, 10);
        wait_done("pkt_long");

        // Next start after a long packet is accepted.
        push_pkt(2, 5, 2);
        start_pkt(2);
        send_pl(2, 2);
        wait_done("pkt_after_long");

        // Out-of-range lengths.
        exp_err++;
        start_pkt(0);
        @(negedge clk);
        chk("busy_len0", 32'(busy), 32'd0);
        exp_err++;
        start_pkt(1481);
        @(negedge clk);
        chk("busy_len1481", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("badlen_err_pulses", 32'(err_seen), 32'(exp_err));

        // Asynchronous reset in the middle of the header.
        ip_ready = 1'b0;
        start_pkt(8);
        repeat (3) @(posedge clk);
        chk("hdr_valid_before_rst", 32'(ip_byte_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(ip_byte_valid), 32'd0);
        chk("midrst_data", 32'(ip_data_out), 32'd0);
        chk("midrst_eof_err", 32'({ip_eof, ip_err}), 32'd0);
        chk("midrst_busy_ready", 32'({busy, pl_ready}), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ip_ready = 1'b1;

        // Ident restarts at 0 after reset.
        push_pkt(1, 0, 1);
        start_pkt(1);
        send_pl(1, 1);
        wait_done("pkt_post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
